// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply/divide engine (Booth multiply, restoring divide)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset_In,
    input  logic             Mult_Start,
    input  logic             Div_Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] High,
    output logic [WIDTH-1:0] Low,
    output logic             Busy,
    output logic             Done,
    output logic             Zero_Div
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t state, state_next;

    // acc: Booth upper accumulator / division remainder (one guard bit so 2^31 fits)
    // q: multiplier / dividend shifting into quotient; m: multiplicand / divisor magnitude
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [WIDTH:0]   m;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             last_iter;

    assign a_abs     = A[WIDTH-1] ? (-A) : A;
    assign b_abs     = B[WIDTH-1] ? (-B) : B;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {1'b0, m};

    // Booth recoding of the current multiplier bit pair: add, subtract or pass the multiplicand
    always_comb begin
        booth_sum = acc;
        case ({q[0], qm1})
            2'b01:   booth_sum = acc + m;
            2'b10:   booth_sum = acc - m;
            default: booth_sum = acc;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (Reset_In) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: multiply wins over divide, divide by zero stays idle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Mult_Start)                     state_next = MULT;
                else if (Div_Start && (B != '0))    state_next = DIV;
            end
            MULT:    if (last_iter) state_next = FINISH;
            DIV:     if (last_iter) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (Reset_In) begin
            acc      <= '0;
            q        <= '0;
            qm1      <= 1'b0;
            m        <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            High     <= '0;
            Low      <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Zero_Div <= 1'b0;
        end else begin
            Done     <= 1'b0;
            Zero_Div <= 1'b0;
            case (state)
                IDLE: begin
                    if (Mult_Start) begin
                        m      <= {A[WIDTH-1], A};
                        q      <= B;
                        qm1    <= 1'b0;
                        acc    <= '0;
                        count  <= '0;
                        is_div <= 1'b0;
                        Busy   <= 1'b1;
                    end else if (Div_Start) begin
                        if (B == '0) begin
                            Zero_Div <= 1'b1;
                        end else begin
                            m      <= {1'b0, b_abs};
                            q      <= a_abs;
                            acc    <= '0;
                            count  <= '0;
                            sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            sign_r <= A[WIDTH-1];
                            is_div <= 1'b1;
                            Busy   <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q     <= {booth_sum[0], q[WIDTH-1:1]};
                    qm1   <= q[0];
                    count <= count + CW'(1);
                end
                DIV: begin
                    if (!div_diff[WIDTH+1]) begin
                        acc <= div_diff[WIDTH:0];
                        q   <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift;
                        q   <= {q[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                end
                FINISH: begin
                    if (is_div) begin
                        Low  <= sign_q ? (-q) : q;
                        High <= sign_r ? (-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
                    end else begin
                        High <= acc[WIDTH-1:0];
                        Low  <= q;
                    end
                    Done <= 1'b1;
                    Busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk;
    logic        Reset_In;
    logic        Mult_Start;
    logic        Div_Start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] High;
    logic [31:0] Low;
    logic        Busy;
    logic        Done;
    logic        Zero_Div;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_high = '0;
    logic [31:0] exp_low  = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .Reset_In   (Reset_In),
        .Mult_Start (Mult_Start),
        .Div_Start  (Div_Start),
        .A          (A),
        .B          (B),
        .High       (High),
        .Low        (Low),
        .Busy       (Busy),
        .Done       (Done),
        .Zero_Div   (Zero_Div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic; SV / truncates toward zero and % follows the dividend
    task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] mh, output logic [31:0] ml);
        longint sa, sb, r;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            v  = 64'(sa * sb);
            mh = v[63:32];
            ml = v[31:0];
        end else begin
            r  = sa / sb;
            v  = 64'(r);
            ml = v[31:0];
            r  = sa % sb;
            v  = 64'(r);
            mh = v[31:0];
        end
    endtask

    // Runs one request; poke_at>0 drives a divide request (or reset) sampled at start edge + poke_at
    task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input bit poke_reset);
        logic [31:0] mh, ml;
        int n;
        bit seen, zd_seen;
        A = a;
        B = b;
        Mult_Start = is_mult;
        Div_Start  = !is_mult;
        @(posedge clk); #1;
        Mult_Start = 1'b0;
        Div_Start  = 1'b0;
        if (!is_mult && b == 32'd0) begin
            check("zdiv_pulse", Zero_Div, 1);
            check("zdiv_busy", Busy, 0);
            check("zdiv_high", High, exp_high);
            check("zdiv_low", Low, exp_low);
            seen = 0;
            zd_seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (Done) seen = 1;
                if (Zero_Div) zd_seen = 1;
                if (Busy) seen = 1;
            end
            check("zdiv_no_done_busy", seen, 0);
            check("zdiv_one_cycle", zd_seen, 0);
            check("zdiv_hold", {High, Low}, {exp_high, exp_low});
            return;
        end
        model(is_mult, a, b, mh, ml);
        check("busy_start", Busy, 1);
        check("no_zdiv", Zero_Div, 0);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            if (n == poke_at - 1) begin
                if (poke_reset) Reset_In = 1'b1;
                else begin
                    A = 32'h1234_5678;
                    B = 32'd2;
                    Div_Start = 1'b1;
                end
            end
            @(posedge clk); #1;
            n++;
            Reset_In  = 1'b0;
            Div_Start = 1'b0;
            if (n == 1) check("hold_while_busy", {High, Low}, {exp_high, exp_low});
            if (poke_reset && n == poke_at) begin
                check("midrst_outs", {High, Low, 29'd0, Busy, Done, Zero_Div}, 96'd0);
                exp_high = '0;
                exp_low  = '0;
            end
            if (Done) seen = 1;
        end
        if (poke_reset) begin
            check("midrst_no_done", seen, 0);
            return;
        end
        check("latency", n, 33);
        check("high", High, mh);
        check("low", Low, ml);
        exp_high = mh;
        exp_low  = ml;
        @(posedge clk); #1;
        check("done_pulse", Done, 0);
        check("busy_end", Busy, 0);
        check("result_hold", {High, Low}, {exp_high, exp_low});
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [0:5];
        int sel;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'h0000_0002;
        sel = $urandom_range(0, 9);
        if (sel < 6) return corner[sel];
        return $urandom;
    endfunction

    initial begin
        Reset_In   = 1'b1;
        Mult_Start = 1'b0;
        Div_Start  = 1'b0;
        A          = '0;
        B          = '0;
        @(posedge clk); @(posedge clk); #1;
        Reset_In = 1'b0;
        check("rst_high", High, 0);
        check("rst_low", Low, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_zdiv", Zero_Div, 0);

        run_op(1, 32'd7, 32'hFFFF_FFFD, 0, 0);
        check("mult_7_m3", {High, Low}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1, 32'h8000_0000, 32'h8000_0000, 10, 0);
        check("mult_min_sq", {High, Low}, 64'h4000_0000_0000_0000);
        run_op(0, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_m7_2", {High, Low}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(0, 32'd100, 32'd7, 0, 0);
        check("div_100_7", {High, Low}, {32'd2, 32'd14});
        run_op(0, 32'd5, 32'd0, 0, 0);
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_overflow", {High, Low}, 64'h0000_0000_8000_0000);
        run_op(1, 32'd3, 32'd4, 10, 1);
        run_op(1, 32'd3, 32'd4, 0, 0);
        check("mult_after_rst", {High, Low}, 64'd12);

        for (int i = 0; i < 30; i++) begin
            run_op($urandom_range(0, 1) == 1, pick_operand(), pick_operand(), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
